// File: rtl/uart_boot_loader.sv
// UART boot loader: parses framed program-load packets from the UART receiver,
// writes payload words into instruction memory and answers with an ACK/NAK byte.
// Frame: SYNC, CNT_LO, CNT_HI, N x 4 bytes (little-endian), CSUM (XOR of all bytes after SYNC).
module uart_boot_loader #(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int unsigned       MAX_WORDS      = 1024,
    parameter int unsigned       TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]        SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]        ACK_BYTE       = 8'h06,
    parameter logic [7:0]        NAK_BYTE       = 8'h15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_ready_i,
    input  logic              rx_error_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StData,
        StCsum,
        StRespWait,
        StResp
    } state_e;

    // Timeout fires on the last idle cycle so the decision lands exactly TIMEOUT_CYCLES
    // cycles after the most recent byte.
    localparam logic [23:0] TimeoutLast = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MaxWords    = 17'(MAX_WORDS);

    state_e      state_q;
    logic [7:0]  cnt_lo_q;
    logic [7:0]  csum_q;
    logic [15:0] word_cnt_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] asm_q;
    logic [23:0] timer_q;
    logic        ack_q;

    logic              in_frame;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] word_off;

    // Decode helpers for the frame-receiving states and the current write address.
    always_comb begin
        in_frame = (state_q == StCntLo) || (state_q == StCntHi) ||
                   (state_q == StData)  || (state_q == StCsum);
        n_words  = {rx_data_i, cnt_lo_q};
        word_off = ADDR_W'({word_idx_q, 2'b00});
    end

    assign busy_o = (state_q != StIdle);

    // Packet parser FSM with registered memory-write and response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_lo_q    <= '0;
            csum_q      <= '0;
            word_cnt_q  <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            timer_q     <= '0;
            ack_q       <= 1'b0;
            tx_data_o   <= '0;
            tx_start_o  <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            mem_we_o   <= 1'b0;
            tx_start_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;

            if (in_frame) begin
                timer_q <= rx_ready_i ? '0 : timer_q + 24'd1;
            end

            if (in_frame && rx_error_i) begin
                // Framing error beats a byte arriving in the same cycle.
                state_q <= StRespWait;
                ack_q   <= 1'b0;
            end else if (in_frame && !rx_ready_i && timer_q == TimeoutLast) begin
                state_q <= StRespWait;
                ack_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (rx_ready_i && rx_data_i == SYNC_BYTE) begin
                            state_q    <= StCntLo;
                            csum_q     <= '0;
                            word_idx_q <= '0;
                            byte_idx_q <= '0;
                            timer_q    <= '0;
                        end
                    end
                    StCntLo: begin
                        if (rx_ready_i) begin
                            cnt_lo_q <= rx_data_i;
                            csum_q   <= csum_q ^ rx_data_i;
                            state_q  <= StCntHi;
                        end
                    end
                    StCntHi: begin
                        if (rx_ready_i) begin
                            csum_q     <= csum_q ^ rx_data_i;
                            word_cnt_q <= n_words;
                            if ({1'b0, n_words} > MaxWords) begin
                                state_q <= StRespWait;
                                ack_q   <= 1'b0;
                            end else if (n_words == 16'd0) begin
                                state_q <= StCsum;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (rx_ready_i) begin
                            csum_q     <= csum_q ^ rx_data_i;
                            byte_idx_q <= byte_idx_q + 2'd1;
                            case (byte_idx_q)
                                2'd0: asm_q[7:0]   <= rx_data_i;
                                2'd1: asm_q[15:8]  <= rx_data_i;
                                2'd2: asm_q[23:16] <= rx_data_i;
                                default: begin
                                    mem_we_o    <= 1'b1;
                                    mem_addr_o  <= BASE_ADDR + word_off;
                                    mem_wdata_o <= {rx_data_i, asm_q};
                                    word_idx_q  <= word_idx_q + 16'd1;
                                    if (word_idx_q + 16'd1 == word_cnt_q) begin
                                        state_q <= StCsum;
                                    end
                                end
                            endcase
                        end
                    end
                    StCsum: begin
                        if (rx_ready_i) begin
                            ack_q   <= (rx_data_i == csum_q);
                            state_q <= StRespWait;
                        end
                    end
                    StRespWait: begin
                        if (!tx_busy_i) begin
                            state_q    <= StResp;
                            tx_start_o <= 1'b1;
                            tx_data_o  <= ack_q ? ACK_BYTE : NAK_BYTE;
                            done_o     <= ack_q;
                            err_o      <= !ack_q;
                        end
                    end
                    StResp: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
